// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: command byte decoder between the UART FIFOs
// and the UART register file; replies with read data or ERR_CODE.
module uart_cmd_bridge #(
  parameter int         ADDR_WIDTH     = 3,
  parameter int         NUM_REGS       = 7,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] ERR_CODE       = 8'hEE
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_fifo_e,
  output logic                  o_rx_rd_en,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_wr_en,
  input  logic                  i_tx_fifo_f,
  output logic [ADDR_WIDTH-1:0] o_rwaddr,
  output logic [7:0]            o_write_data,
  output logic                  o_wr_req,
  output logic                  o_rd_req,
  input  logic [7:0]            i_read_data,
  output logic                  o_err,
  output logic                  o_busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_WAIT_DATA = 3'd2;
  localparam logic [2:0] S_WRITE     = 3'd3;
  localparam logic [2:0] S_READ_REQ  = 3'd4;
  localparam logic [2:0] S_READ_WAIT = 3'd5;
  localparam logic [2:0] S_SEND      = 3'd6;
  localparam logic [2:0] S_ERR       = 3'd7;

  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic [7:0]    cmd_q;
  logic [7:0]    wdata_q;
  logic [7:0]    txd_q;
  logic [CW-1:0] cnt_q;
  logic          pop;
  logic          push;
  logic          err_p;
  logic          illegal;
  logic          last;

  assign illegal =
    (cmd_q[6:ADDR_WIDTH] != '0) ||
    (32'(cmd_q[ADDR_WIDTH-1:0]) >= 32'(NUM_REGS));
  assign last = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Next-state and handshake strobes; an arriving byte beats the timeout
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    push    = 1'b0;
    err_p   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!i_rx_fifo_e) begin
          pop     = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          err_p   = 1'b1;
          state_d = S_ERR;
        end else if (cmd_q[7]) begin
          state_d = S_WAIT_DATA;
        end else begin
          state_d = S_READ_REQ;
        end
      end
      S_WAIT_DATA: begin
        if (!i_rx_fifo_e) begin
          pop     = 1'b1;
          state_d = S_WRITE;
        end else if (last) begin
          err_p   = 1'b1;
          state_d = S_ERR;
        end
      end
      S_WRITE:     state_d = S_IDLE;
      S_READ_REQ:  state_d = S_READ_WAIT;
      S_READ_WAIT: state_d = S_SEND;
      S_SEND, S_ERR: begin
        if (!i_tx_fifo_f) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, command/data latches, timeout counter and reply byte
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      wdata_q <= '0;
      txd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && pop)
        cmd_q <= i_rx_data;
      if (state_q == S_DECODE)
        cnt_q <= '0;
      else if (state_q == S_WAIT_DATA && !pop)
        cnt_q <= cnt_q + CW'(1);
      if (state_q == S_WAIT_DATA && pop)
        wdata_q <= i_rx_data;
      if (state_q == S_READ_WAIT)
        txd_q <= i_read_data;
      if (err_p)
        txd_q <= ERR_CODE;
    end
  end

  assign o_rx_rd_en   = pop & ~i_rst;
  assign o_tx_wr_en   = push & ~i_rst;
  assign o_err        = err_p & ~i_rst;
  assign o_wr_req     = (state_q == S_WRITE) & ~i_rst;
  assign o_rd_req     = (state_q == S_READ_REQ) & ~i_rst;
  assign o_busy       = (state_q != S_IDLE) & ~i_rst;
  assign o_rwaddr     = cmd_q[ADDR_WIDTH-1:0];
  assign o_write_data = wdata_q;
  assign o_tx_data    = txd_q;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb_uart_cmd_bridge: directed and random command streams checked
// against a byte-level protocol model of the bridge.
module tb_uart_cmd_bridge;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data;
  logic       rx_e;
  logic       rd_en;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_f;
  logic [2:0] rwaddr;
  logic [7:0] wdata;
  logic       wr_req;
  logic       rd_req;
  logic [7:0] rdata;
  logic       err;
  logic       busy;

  logic [7:0]  rxq[$];
  logic [7:0]  txlog[$];
  logic [10:0] wrlog[$];
  logic [2:0]  rdlog[$];
  logic [7:0]  exp_tx[$];
  logic [10:0] exp_wr[$];
  logic [7:0]  env_regs[8];
  logic [7:0]  m_regs[8];
  int exp_err;
  int errcnt;
  int cyc;
  int popcnt;
  int first_pop;
  int last_pop;
  int rd_cyc;
  int tx_cyc;
  int wr_cyc;
  int err_cyc;
  int checks;
  int errors;
  bit pop_pend;
  bit rd_pend;
  logic [2:0] rd_addr;
  bq_t seg;

  uart_cmd_bridge #(
    .ADDR_WIDTH(3),
    .NUM_REGS(7),
    .TIMEOUT_CYCLES(16),
    .ERR_CODE(8'hEE)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rx_data(rx_data),
    .i_rx_fifo_e(rx_e),
    .o_rx_rd_en(rd_en),
    .o_tx_data(tx_data),
    .o_tx_wr_en(tx_wr),
    .i_tx_fifo_f(tx_f),
    .o_rwaddr(rwaddr),
    .o_write_data(wdata),
    .o_wr_req(wr_req),
    .o_rd_req(rd_req),
    .i_read_data(rdata),
    .o_err(err),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void rx_upd();
    rx_e    = (rxq.size() == 0);
    rx_data = rx_e ? 8'h00 : rxq[0];
  endfunction

  // Monitor: sample outputs mid-cycle, log transactions
  always @(negedge clk) begin
    cyc++;
    if (rd_en) begin
      chk("rx_pop_nonempty", 32'(rx_e), 32'(0));
      pop_pend = 1'b1;
      popcnt++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (tx_wr) begin
      chk("tx_push_notfull", 32'(tx_f), 32'(0));
      txlog.push_back(tx_data);
      tx_cyc = cyc;
    end
    if (wr_req || rd_req)
      chk("wr_rd_excl", 32'(wr_req && rd_req), 32'(0));
    if (wr_req) begin
      wrlog.push_back({rwaddr, wdata});
      env_regs[rwaddr] = wdata;
      wr_cyc = cyc;
    end
    if (rd_req) begin
      rdlog.push_back(rwaddr);
      rd_pend = 1'b1;
      rd_addr = rwaddr;
      rd_cyc  = cyc;
    end
    if (err) begin
      errcnt++;
      err_cyc = cyc;
    end
  end

  // FIFO and register file side effects just after the edge
  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      void'(rxq.pop_front());
      pop_pend = 1'b0;
      rx_upd();
    end
    if (rd_pend) begin
      rdata   = env_regs[rd_addr];
      rd_pend = 1'b0;
    end
  end

  task automatic model(input bq_t s);
    int i;
    logic [7:0] c;
    logic [7:0] d;
    i = 0;
    exp_tx.delete();
    exp_wr.delete();
    exp_err = 0;
    while (i < s.size()) begin
      c = s[i];
      i++;
      if (c[6:3] != 4'd0 || c[2:0] > 3'd6) begin
        exp_tx.push_back(8'hEE);
        exp_err++;
      end else if (c[7]) begin
        d = s[i];
        i++;
        m_regs[c[2:0]] = d;
        exp_wr.push_back({c[2:0], d});
      end else begin
        exp_tx.push_back(m_regs[c[2:0]]);
      end
    end
  endtask

  task automatic clear_logs();
    txlog.delete();
    wrlog.delete();
    rdlog.delete();
    errcnt    = 0;
    first_pop = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(string tag, input bit bp);
    int n;
    n = 0;
    while (!(rxq.size() == 0 && !busy) && n < 3000) begin
      tick();
      if (bp) tx_f = ($urandom_range(0, 2) == 0);
      n++;
    end
    tx_f = 1'b0;
    chk({tag, "_drain"}, 32'(n < 3000), 32'(1));
  endtask

  task automatic wait_pop(string tag);
    int b;
    int n;
    b = popcnt;
    n = 0;
    do begin
      tick();
      n++;
    end while (popcnt == b && n < 50);
    chk({tag, "_pop"}, 32'(popcnt != b), 32'(1));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_rd_en"}, 32'(rd_en), 32'(0));
    chk({tag, "_tx_wr"}, 32'(tx_wr), 32'(0));
    chk({tag, "_wr_req"}, 32'(wr_req), 32'(0));
    chk({tag, "_rd_req"}, 32'(rd_req), 32'(0));
    chk({tag, "_err"}, 32'(err), 32'(0));
    chk({tag, "_rwaddr"}, 32'(rwaddr), 32'(0));
    chk({tag, "_wdata"}, 32'(wdata), 32'(0));
    chk({tag, "_txdata"}, 32'(tx_data), 32'(0));
  endtask

  task automatic cmp_logs(string tag);
    chk({tag, "_ntx"}, 32'(txlog.size()), 32'(exp_tx.size()));
    foreach (exp_tx[i])
      if (i < txlog.size())
        chk({tag, "_tx"}, 32'(txlog[i]), 32'(exp_tx[i]));
    chk({tag, "_nwr"}, 32'(wrlog.size()), 32'(exp_wr.size()));
    foreach (exp_wr[i])
      if (i < wrlog.size())
        chk({tag, "_wr"}, 32'(wrlog[i]), 32'(exp_wr[i]));
    chk({tag, "_nerr"}, 32'(errcnt), 32'(exp_err));
  endtask

  task automatic run_seg(input bq_t s, input bit bp,
                         input string tag);
    clear_logs();
    model(s);
    foreach (s[i]) rxq.push_back(s[i]);
    rx_upd();
    wait_idle(tag, bp);
    cmp_logs(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int k;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    popcnt    = 0;
    first_pop = -1;
    tx_f      = 1'b0;
    rdata     = 8'h00;
    rx_upd();
    for (int i = 0; i < 8; i++) begin
      v = 8'($urandom);
      env_regs[i] = v;
      m_regs[i]   = v;
    end
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    env_regs[1] = 8'h5A;
    m_regs[1]   = 8'h5A;
    seg.delete();
    seg.push_back(8'h01);
    run_seg(seg, 1'b0, "read");
    chk("read_rd_lat", 32'(rd_cyc - first_pop), 32'(2));
    chk("read_tx_lat", 32'(tx_cyc - first_pop), 32'(4));
    chk("read_nrd", 32'(rdlog.size()), 32'(1));
    if (rdlog.size() > 0)
      chk("read_addr", 32'(rdlog[0]), 32'(1));

    seg.delete();
    seg.push_back(8'h82);
    seg.push_back(8'h34);
    seg.push_back(8'h83);
    seg.push_back(8'h12);
    run_seg(seg, 1'b0, "wstream");

    seg.delete();
    seg.push_back(8'h07);
    run_seg(seg, 1'b0, "ill_off");
    chk("ill_off_nrd", 32'(rdlog.size()), 32'(0));
    seg.delete();
    seg.push_back(8'h41);
    run_seg(seg, 1'b0, "ill_rsv");
    chk("ill_rsv_nrd", 32'(rdlog.size()), 32'(0));

    clear_logs();
    rxq.push_back(8'h80);
    rx_upd();
    wait_pop("to");
    k = 0;
    while (errcnt == 0 && k < 40) begin
      tick();
      k++;
    end
    chk("to_err_lat", 32'(err_cyc - first_pop), 32'(17));
    wait_idle("to", 1'b0);
    chk("to_nerr", 32'(errcnt), 32'(1));
    chk("to_ntx", 32'(txlog.size()), 32'(1));
    if (txlog.size() > 0)
      chk("to_tx", 32'(txlog[0]), 32'(8'hEE));
    chk("to_nwr", 32'(wrlog.size()), 32'(0));

    clear_logs();
    rxq.push_back(8'h80);
    rx_upd();
    wait_pop("tolast");
    repeat (16) tick();
    rxq.push_back(8'hAB);
    rx_upd();
    wait_idle("tolast", 1'b0);
    m_regs[0] = 8'hAB;
    chk("tolast_pop_lat", 32'(last_pop - first_pop), 32'(17));
    chk("tolast_wr_lat", 32'(wr_cyc - last_pop), 32'(1));
    chk("tolast_nerr", 32'(errcnt), 32'(0));
    chk("tolast_ntx", 32'(txlog.size()), 32'(0));
    chk("tolast_nwr", 32'(wrlog.size()), 32'(1));
    if (wrlog.size() > 0)
      chk("tolast_wr", 32'(wrlog[0]), 32'({3'd0, 8'hAB}));

    clear_logs();
    tx_f = 1'b1;
    rxq.push_back(8'h00);
    rx_upd();
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (j >= 4) begin
        chk("bp_hold_data", 32'(tx_data), 32'(m_regs[0]));
        chk("bp_hold_busy", 32'(busy), 32'(1));
      end
    end
    chk("bp_nopush", 32'(txlog.size()), 32'(0));
    tick();
    tx_f = 1'b0;
    repeat (4) tick();
    chk("bp_push_cyc", 32'(tx_cyc - first_pop), 32'(11));
    chk("bp_ntx", 32'(txlog.size()), 32'(1));
    if (txlog.size() > 0)
      chk("bp_tx", 32'(txlog[0]), 32'(m_regs[0]));
    chk("bp_idle", 32'(busy), 32'(0));

    clear_logs();
    rxq.push_back(8'h81);
    rx_upd();
    wait_pop("rst");
    tick();
    chk("rst_busy_wait", 32'(busy), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("rst_mid");
    rxq.push_back(8'hAA);
    rx_upd();
    wait_idle("rst", 1'b0);
    chk("rst_nerr", 32'(errcnt), 32'(1));
    chk("rst_ntx", 32'(txlog.size()), 32'(1));
    if (txlog.size() > 0)
      chk("rst_tx", 32'(txlog[0]), 32'(8'hEE));
    chk("rst_nwr", 32'(wrlog.size()), 32'(0));

    for (int r = 0; r < 3; r++) begin
      seg.delete();
      for (int c = 0; c < 30; c++) begin
        k = int'($urandom_range(0, 9));
        if (k < 2) begin
          if ($urandom_range(0, 1) == 0)
            seg.push_back({1'($urandom), 4'd0, 3'd7});
          else
            seg.push_back({1'($urandom),
                           4'($urandom_range(1, 15)),
                           3'($urandom)});
        end else if (k < 6) begin
          seg.push_back({1'b1, 4'd0, 3'($urandom_range(0, 6))});
          seg.push_back(8'($urandom));
        end else begin
          seg.push_back({1'b0, 4'd0, 3'($urandom_range(0, 6))});
        end
      end
      run_seg(seg, r != 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_bridge.md
Name: uart_cmd_bridge

Overview:
- Command-protocol master between the UART RX/TX FIFOs and the UART register file.
- Pops command bytes from the RX FIFO and decodes them into single-cycle register read/write requests (rwaddr, write data, rd_req, wr_req).
- Returns register read data, or an error code, to the host through the TX FIFO.
- Register writes are silent, which lets the host stream ECG samples (DINL then DINH) with no reply traffic.

Parameters:
- ADDR_WIDTH, 3: register offset width.
- NUM_REGS, 7: number of valid offsets; valid offsets are 0..NUM_REGS-1.
- TIMEOUT_CYCLES, 1000000: maximum clock cycles to wait for a write data byte.
- ERR_CODE, 8'hEE: byte sent to the host on a protocol error.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_rx_data  in  8  RX FIFO head byte (first-word-fall-through; valid while !i_rx_fifo_e)
- i_rx_fifo_e  in  1  RX FIFO empty
- o_rx_rd_en  out  1  pop the RX FIFO head this cycle
- o_tx_data  out  8  byte to the TX FIFO
- o_tx_wr_en  out  1  push o_tx_data this cycle
- i_tx_fifo_f  in  1  TX FIFO full
- o_rwaddr  out  ADDR_WIDTH  register offset
- o_write_data  out  8  register write data
- o_wr_req  out  1  single-cycle register write strobe
- o_rd_req  out  1  single-cycle register read strobe
- i_read_data  in  8  register read data, valid the cycle after o_rd_req
- o_err  out  1  single-cycle pulse on a protocol error
- o_busy  out  1  high whenever the state is not IDLE

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: state IDLE; every output 0; timeout counter 0; command and data latches 0.
- Reset mid-operation: i_rst asserted in any state aborts the transaction.
  - No request is issued for a partial command.
  - Bytes already popped are lost.
- Command byte format:
  - bit7: 1 = write, 0 = read.
  - bits[6:ADDR_WIDTH]: must be 0.
  - bits[ADDR_WIDTH-1:0]: register offset.
  - The command is illegal if any reserved bit is set or if offset >= NUM_REGS.
- A write command is followed by exactly one data byte.
- FSM states and transitions:
  - IDLE: if !i_rx_fifo_e, assert o_rx_rd_en, latch i_rx_data as the command, go to DECODE.
  - DECODE:
    - Drive o_rwaddr from the command.
    - Illegal command: go to ERR and pulse o_err this cycle.
    - Write: go to WAIT_DATA and clear the timeout counter.
    - Read: go to READ_REQ.
  - WAIT_DATA:
    - If !i_rx_fifo_e: assert o_rx_rd_en, latch the byte into o_write_data, go to WRITE.
    - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1, go to ERR and pulse o_err.
    - A byte arriving on the timeout cycle takes priority: it is accepted and there is no error.
  - WRITE: o_wr_req=1 for exactly one cycle, then IDLE.
  - READ_REQ: o_rd_req=1 for exactly one cycle, then READ_WAIT.
  - READ_WAIT: latch i_read_data into o_tx_data, go to SEND.
  - SEND:
    - If !i_tx_fifo_f: o_tx_wr_en=1 for one cycle, then IDLE.
    - Otherwise hold, with o_tx_data stable.
  - ERR: o_tx_data=ERR_CODE, then the same full/push rule as SEND, then IDLE.
- Signal stability:
  - o_rwaddr is stable from DECODE until the state returns to IDLE.
  - o_write_data is stable through WRITE.
- Exclusivity:
  - o_wr_req and o_rd_req are never high together.
  - o_rx_rd_en is never asserted while i_rx_fifo_e=1.
  - o_tx_wr_en is never asserted while i_tx_fifo_f=1.
- Latency, with cycle 0 = command pop in IDLE:
  - Read: o_rd_req at cycle 2; o_tx_wr_en at cycle 4 when the TX FIFO is not full.
  - Write: the data pop happens in cycle 2 at the earliest; o_wr_req follows one cycle after the data pop (cycle 3 minimum).
- Throughput: the next command is accepted in the IDLE cycle right after WRITE or SEND completes. There are no back-to-back pops across transactions.
- Error recovery: no resynchronisation beyond the ERR reply. The byte following an illegal command is parsed as a new command.

Test Plan:
- Read: RX holds 8'h01, register file returns 8'h5A -> o_rd_req at cycle 2 with o_rwaddr=1; o_tx_wr_en at cycle 4 with o_tx_data=8'h5A; o_err never asserted.
- Write stream: RX holds 8'h82, 8'h34, 8'h83, 8'h12 -> two o_wr_req pulses: (addr 2, data 8'h34) then (addr 3, data 8'h12); no TX pushes; o_rx_rd_en never asserted with RX empty.
- Illegal commands:
  - 8'h07 (offset 7) -> o_err pulse, one TX push of 8'hEE, no rd/wr request.
  - 8'h41 (reserved bit set) -> same response.
- Timeout: 8'h80 followed by no data, TIMEOUT_CYCLES=16 -> o_err pulse 16 cycles after DECODE and an 8'hEE push. Repeat with the data byte arriving exactly on cycle 15 -> write performed, no error.
- TX backpressure: read command 8'h00 with i_tx_fifo_f held high for 10 cycles -> the FSM holds in SEND with o_tx_data stable; the push occurs on the first cycle i_tx_fifo_f=0; no duplicate push.
- Reset: assert i_rst for one cycle after popping 8'h81 (in WAIT_DATA), then supply 8'hAA -> all outputs 0 after reset; 8'hAA is parsed as a new command (illegal: reserved bits set) -> o_err pulse and an 8'hEE push; no write issued.
